// File: rtl/cov_mem_arbiter_if.sv
// Requester-side bus of the Cov_MEM arbiter: one instance per master
// (host/loader or convolution core).
interface cov_mem_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              req;
    logic              we;
    logic              lock;
    logic [ADDR_W-1:0] adr;
    logic [DATA_W-1:0] wdata;
    logic              gnt;
    logic              rvalid;
    logic [DATA_W-1:0] rdata;

    modport master (
        output req, we, lock, adr, wdata,
        input  gnt, rvalid, rdata
    );

    modport slave (
        input  req, we, lock, adr, wdata,
        output gnt, rvalid, rdata
    );
endinterface

// File: rtl/cov_mem_arbiter.sv
// Round-robin arbiter with burst lock sharing the single-port Cov_MEM between
// the loader (m0) and Cov_Top (m1); registers the RAM command and routes read data back.
module cov_mem_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int RD_LAT = 1
) (
    input  logic              clk,
    input  logic              reset,
    cov_mem_arbiter_if.slave  m0,
    cov_mem_arbiter_if.slave  m1,
    output logic [ADDR_W-1:0] ram_adr,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata,
    output logic              ram_wr_en,
    output logic              ram_rd_en,
    output logic              busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOCK0 = 2'd1,
        LOCK1 = 2'd2
    } state_t;

    state_t            state;
    logic              rr_last;
    logic              gnt0;
    logic              gnt1;
    logic              any_gnt;
    logic              win_we;
    logic [ADDR_W-1:0] win_adr;
    logic [DATA_W-1:0] win_wdata;

    // Read tags: bit k is the tag k+1 edges after the granting edge.
    logic [RD_LAT:0]   tag_vld_p;
    logic [RD_LAT:0]   tag_id_p;
    logic [DATA_W-1:0] m0_rdata_q;
    logic [DATA_W-1:0] m1_rdata_q;

    // Grant decode: combinational from state, rr_last and requests only.
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        case (state)
            IDLE: begin
                gnt0 = m0.req & (~m1.req | rr_last);
                gnt1 = m1.req & (~m0.req | ~rr_last);
            end
            LOCK0:   gnt0 = m0.req;
            LOCK1:   gnt1 = m1.req;
            default: begin
                gnt0 = 1'b0;
                gnt1 = 1'b0;
            end
        endcase
    end

    assign any_gnt   = gnt0 | gnt1;
    assign win_we    = gnt1 ? m1.we    : m0.we;
    assign win_adr   = gnt1 ? m1.adr   : m0.adr;
    assign win_wdata = gnt1 ? m1.wdata : m0.wdata;

    assign m0.gnt = gnt0;
    assign m1.gnt = gnt1;

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            rr_last <= 1'b1;
        end else if (gnt0) begin
            rr_last <= 1'b0;
            state   <= m0.lock ? LOCK0 : IDLE;
        end else if (gnt1) begin
            rr_last <= 1'b1;
            state   <= m1.lock ? LOCK1 : IDLE;
        end else begin
            // A lock owner that drops its request gives the RAM back.
            state <= IDLE;
        end
    end

    // Stage p0: registered RAM command, on the pins the cycle after the grant.
    always_ff @(posedge clk) begin
        if (reset) begin
            ram_adr   <= '0;
            ram_wdata <= '0;
            ram_wr_en <= 1'b0;
            ram_rd_en <= 1'b0;
        end else begin
            ram_wr_en <= any_gnt & win_we;
            ram_rd_en <= any_gnt & ~win_we;
            if (any_gnt) begin
                ram_adr   <= win_adr;
                ram_wdata <= win_wdata;
            end
        end
    end

    // Stages p0..pRD_LAT: read tag shift register, last stage is rvalid.
    always_ff @(posedge clk) begin
        if (reset) begin
            tag_vld_p <= '0;
            tag_id_p  <= '0;
        end else begin
            tag_vld_p <= {tag_vld_p[RD_LAT-1:0], any_gnt & ~win_we};
            tag_id_p  <= {tag_id_p[RD_LAT-1:0], gnt1};
        end
    end

    // RAM data is sampled on the same edge that moves the tag into the last stage.
    always_ff @(posedge clk) begin
        if (reset) begin
            m0_rdata_q <= '0;
            m1_rdata_q <= '0;
        end else begin
            if (tag_vld_p[RD_LAT-1] & ~tag_id_p[RD_LAT-1])
                m0_rdata_q <= ram_rdata;
            if (tag_vld_p[RD_LAT-1] & tag_id_p[RD_LAT-1])
                m1_rdata_q <= ram_rdata;
        end
    end

    assign m0.rvalid = tag_vld_p[RD_LAT] & ~tag_id_p[RD_LAT];
    assign m1.rvalid = tag_vld_p[RD_LAT] & tag_id_p[RD_LAT];
    assign m0.rdata  = m0_rdata_q;
    assign m1.rdata  = m1_rdata_q;

    assign busy = (|tag_vld_p) | (state != IDLE);

endmodule

// File: tb/tb_cov_mem_arbiter.sv
// Randomized scoreboard bench for cov_mem_arbiter with a 64-word RAM model.
module tb_cov_mem_arbiter;
    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int RD_LAT = 1;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] ram_adr;
    logic [31:0] ram_wdata;
    logic [31:0] ram_rdata;
    logic        ram_wr_en;
    logic        ram_rd_en;
    logic        busy;
    int          cyc = 0;

    cov_mem_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) m0_if ();
    cov_mem_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) m1_if ();

    cov_mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LAT(RD_LAT)) dut (
        .clk       (clk),
        .reset     (reset),
        .m0        (m0_if),
        .m1        (m1_if),
        .ram_adr   (ram_adr),
        .ram_wdata (ram_wdata),
        .ram_rdata (ram_rdata),
        .ram_wr_en (ram_wr_en),
        .ram_rd_en (ram_rd_en),
        .busy      (busy)
    );

    initial forever #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // RAM model: writes commit at the edge, reads are combinational (RD_LAT=1).
    logic [31:0] ram_arr [64];
    always @(posedge clk) if (ram_wr_en) ram_arr[ram_adr[5:0]] <= ram_wdata;
    assign ram_rdata = ram_arr[ram_adr[5:0]];

    typedef struct { int cyc; logic wr; logic [31:0] adr; logic [31:0] wdata; } cmd_t;
    typedef struct { int cyc; int id; logic [31:0] data; } rd_t;
    cmd_t cmd_q[$];
    rd_t  rd_q[$];

    int errors = 0;
    int checks = 0;

    int          mdl_owner;
    int          mdl_last;
    int          last_rd_g;
    logic [31:0] mdl_mem [64];
    int          obs_win;
    logic [31:0] mon_last [2];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic model_reset();
        mdl_owner = -1;
        mdl_last  = 1;
        last_rd_g = -1000;
        cmd_q.delete();
        rd_q.delete();
    endtask

    // One cycle: drive inputs, predict the grant, check gnt/busy, queue expected responses.
    task automatic step(input logic r0, input logic we0, input logic lk0,
                        input logic [31:0] a0, input logic [31:0] d0,
                        input logic r1, input logic we1, input logic lk1,
                        input logic [31:0] a1, input logic [31:0] d1);
        int   win;
        logic wwe;
        logic wlk;
        logic [31:0] wa;
        logic [31:0] wd;
        logic exp_busy;
        m0_if.req = r0; m0_if.we = we0; m0_if.lock = lk0; m0_if.adr = a0; m0_if.wdata = d0;
        m1_if.req = r1; m1_if.we = we1; m1_if.lock = lk1; m1_if.adr = a1; m1_if.wdata = d1;
        @(negedge clk);
        exp_busy = (mdl_owner >= 0) || ((cyc - last_rd_g) >= 1 && (cyc - last_rd_g) <= RD_LAT + 1);
        chk("busy", {31'd0, busy}, {31'd0, exp_busy});
        if (mdl_owner < 0) begin
            if (r0 && r1)  win = (mdl_last == 1) ? 0 : 1;
            else if (r0)   win = 0;
            else if (r1)   win = 1;
            else           win = -1;
        end else begin
            win = ((mdl_owner == 0) ? r0 : r1) ? mdl_owner : -1;
        end
        chk("gnt0", {31'd0, m0_if.gnt}, {31'd0, win == 0});
        chk("gnt1", {31'd0, m1_if.gnt}, {31'd0, win == 1});
        obs_win = m0_if.gnt ? 0 : (m1_if.gnt ? 1 : -1);
        if (win >= 0) begin
            wwe = (win == 1) ? we1 : we0;
            wlk = (win == 1) ? lk1 : lk0;
            wa  = (win == 1) ? a1  : a0;
            wd  = (win == 1) ? d1  : d0;
            cmd_q.push_back('{cyc + 1, wwe, wa, wd});
            if (wwe) begin
                mdl_mem[wa[5:0]] = wd;
            end else begin
                rd_q.push_back('{cyc + 1 + RD_LAT, win, mdl_mem[wa[5:0]]});
                last_rd_g = cyc;
            end
            mdl_last  = win;
            mdl_owner = wlk ? win : -1;
        end else begin
            mdl_owner = -1;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        m0_if.req = 0; m0_if.we = 0; m0_if.lock = 0; m0_if.adr = 0; m0_if.wdata = 0;
        m1_if.req = 0; m1_if.we = 0; m1_if.lock = 0; m1_if.adr = 0; m1_if.wdata = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic check_zero();
        @(negedge clk);
        chk("rst_ram_adr",   ram_adr,   32'd0);
        chk("rst_ram_wdata", ram_wdata, 32'd0);
        chk("rst_wr_en",     {31'd0, ram_wr_en}, 32'd0);
        chk("rst_rd_en",     {31'd0, ram_rd_en}, 32'd0);
        chk("rst_m0_rvalid", {31'd0, m0_if.rvalid}, 32'd0);
        chk("rst_m1_rvalid", {31'd0, m1_if.rvalid}, 32'd0);
        chk("rst_m0_rdata",  m0_if.rdata, 32'd0);
        chk("rst_m1_rdata",  m1_if.rdata, 32'd0);
        chk("rst_gnt",       {30'd0, m1_if.gnt, m0_if.gnt}, 32'd0);
        chk("rst_busy",      {31'd0, busy}, 32'd0);
        repeat (RD_LAT + 2) begin
            @(negedge clk);
            chk("rst_no_rvalid", {30'd0, m1_if.rvalid, m0_if.rvalid}, 32'd0);
        end
        @(posedge clk);
        #1;
    endtask

    // Monitor: pops the scoreboard whenever the DUT presents a command or read data.
    initial begin
        cmd_t c;
        rd_t  r;
        logic rv;
        logic [31:0] rdat;
        forever begin
            @(negedge clk);
            if (reset) begin
                mon_last[0] = 32'd0;
                mon_last[1] = 32'd0;
            end else begin
                while (cmd_q.size() > 0 && cmd_q[0].cyc < cyc) begin
                    chk("cmd_missing", cyc, cmd_q[0].cyc);
                    void'(cmd_q.pop_front());
                end
                if (ram_wr_en || ram_rd_en) begin
                    if (cmd_q.size() == 0) begin
                        chk("cmd_unexpected", {30'd0, ram_wr_en, ram_rd_en}, 32'd0);
                    end else begin
                        c = cmd_q.pop_front();
                        chk("cmd_cycle", cyc, c.cyc);
                        chk("ram_wr_en", {31'd0, ram_wr_en}, {31'd0, c.wr});
                        chk("ram_rd_en", {31'd0, ram_rd_en}, {31'd0, ~c.wr});
                        chk("ram_adr", ram_adr, c.adr);
                        if (c.wr) chk("ram_wdata", ram_wdata, c.wdata);
                    end
                end
                while (rd_q.size() > 0 && rd_q[0].cyc < cyc) begin
                    chk("rvalid_missing", cyc, rd_q[0].cyc);
                    void'(rd_q.pop_front());
                end
                for (int x = 0; x < 2; x++) begin
                    rv   = (x == 1) ? m1_if.rvalid : m0_if.rvalid;
                    rdat = (x == 1) ? m1_if.rdata  : m0_if.rdata;
                    if (rv) begin
                        if (rd_q.size() == 0) begin
                            chk("rvalid_unexpected", {31'd0, rv}, 32'd0);
                        end else begin
                            r = rd_q.pop_front();
                            chk("rvalid_master", x, r.id);
                            chk("rvalid_cycle", cyc, r.cyc);
                            chk("rdata", rdat, r.data);
                            mon_last[x] = r.data;
                        end
                    end else begin
                        chk("rdata_hold", rdat, mon_last[x]);
                    end
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int exp_burst [4];
        exp_burst = '{1, 1, 1, 0};
        apply_reset();
        check_zero();

        // Single master write.
        step(1, 1, 0, 32'h10, 32'hDEADBEEF, 0, 0, 0, 0, 0);
        chk("wr_win", obs_win, 0);

        // m1 read-back of the same word.
        step(0, 0, 0, 0, 0, 1, 0, 0, 32'h10, 0);
        chk("rd_win", obs_win, 1);
        repeat (RD_LAT + 2) idle();

        // Round-robin under continuous contention.
        for (int i = 0; i < 4; i++) begin
            step(1, 0, 0, 32'h10, 0, 1, 0, 0, 32'h10, 0);
            chk("rr_win", obs_win, i % 2);
        end
        step(1, 1, 0, 32'h20, 32'h12345678, 0, 0, 0, 0, 0);
        chk("pre_burst_win", obs_win, 0);

        // m1 locked read burst while m0 keeps requesting.
        for (int i = 0; i < 4; i++) begin
            step(1, 1, 0, 32'h21, 32'hA5A5_0000 + i,
                 (i < 3), 0, (i < 2), 32'h10, 0);
            chk("burst_win", obs_win, exp_burst[i]);
        end

        // m0 takes a lock then abandons it.
        step(1, 1, 1, 32'h22, 32'hCAFEF00D, 0, 0, 0, 0, 0);
        chk("abandon_lock_win", obs_win, 0);
        step(0, 0, 0, 0, 0, 1, 0, 0, 32'h10, 0);
        chk("abandon_locked_out", obs_win, -1);
        step(0, 0, 0, 0, 0, 1, 0, 0, 32'h10, 0);
        chk("abandon_m1_win", obs_win, 1);
        repeat (RD_LAT + 2) idle();

        // Reset the cycle after an m1 read grant.
        step(0, 0, 0, 0, 0, 1, 0, 0, 32'h10, 0);
        chk("midrd_win", obs_win, 1);
        apply_reset();
        check_zero();

        // Preload every RAM word, then random traffic.
        for (int i = 0; i < 64; i++)
            step(1, 1, 0, i, $urandom, 0, 0, 0, 0, 0);
        for (int i = 0; i < 400; i++) begin
            step($urandom_range(0, 9) < 7, 1'($urandom_range(0, 1)), $urandom_range(0, 3) == 0,
                 $urandom_range(0, 63), $urandom,
                 $urandom_range(0, 9) < 7, 1'($urandom_range(0, 1)), $urandom_range(0, 3) == 0,
                 $urandom_range(0, 63), $urandom);
        end
        repeat (RD_LAT + 4) idle();
        chk("cmd_q_drained", cmd_q.size(), 0);
        chk("rd_q_drained", rd_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/cov_mem_arbiter.md
Name: cov_mem_arbiter

Overview:
- Shares the single-port convolution data RAM (Cov_MEM) between two requesters: master 0 (host/loader, which preloads weights and images) and master 1 (the Cov_Top convolution core).
- Round-robin arbitration, with a lock for bursts. The RAM command is registered, and read data is routed back to the master that issued the read.
- Sits between Cov_Top/loader and Cov_MEM, and drives Cov_MEM's ADR, DIN, wr_en and rd_en.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width.
- RD_LAT, 1, number of cycles from a read command on the RAM pins to valid RAM read data (range 1-4).

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- reset  in  1  synchronous, active-high reset.
- m0_req  in  1  master 0 access request.
- m0_we  in  1  master 0 access type: 1 = write, 0 = read.
- m0_lock  in  1  master 0 holds ownership after this access.
- m0_adr  in  ADDR_W  master 0 address.
- m0_wdata  in  DATA_W  master 0 write data.
- m0_gnt  out  1  master 0 access accepted this cycle (combinational).
- m0_rvalid  out  1  master 0 read data valid.
- m0_rdata  out  DATA_W  master 0 read data.
- m1_req, m1_we, m1_lock, m1_adr, m1_wdata, m1_gnt, m1_rvalid, m1_rdata  same as master 0, for master 1.
- ram_adr  out  ADDR_W  registered RAM address.
- ram_wdata  out  DATA_W  registered RAM write data (to Cov_MEM DIN).
- ram_rdata  in  DATA_W  RAM read data (from Cov_MEM DOUT).
- ram_wr_en  out  1  registered RAM write strobe.
- ram_rd_en  out  1  registered RAM read strobe.
- busy  out  1  high while any read is in flight or a lock is held.

Behaviour:
- Reset: FSM to IDLE, rr_last=1 (so master 0 wins the first tie). ram_adr=0, ram_wdata=0, ram_wr_en=0, ram_rd_en=0. Read tag pipeline cleared; all rvalid=0, rdata=0, gnt=0, busy=0.
- Reset mid-operation: in-flight reads are discarded; no rvalid is produced after reset.
- FSM states:
  - IDLE: only m0 req -> grant 0; only m1 req -> grant 1; both req -> grant ~rr_last.
  - Granting x with mx_lock=1 -> next state LOCKx.
  - LOCKx: only x can be granted; the other master's gnt is forced 0.
    - x req with lock=1 -> stay in LOCKx.
    - x req with lock=0 -> grant, then go to IDLE.
    - x req=0 -> go to IDLE with no grant.
- rr_last is updated to the winner on every grant.
- At most one grant per cycle; gnt depends only on state, rr_last and req.
- Grant in cycle N:
  - The edge at the end of N registers ram_adr, ram_wdata, ram_wr_en=we and ram_rd_en=~we; these are on the RAM pins in cycle N+1.
  - With no grant, wr_en and rd_en register to 0; adr/wdata hold their previous value.
- Read return:
  - An RD_LAT+1 deep shift register carries {valid, master_id}.
  - mx_rvalid=1 in cycle N+1+RD_LAT for exactly one cycle; mx_rdata is registered from ram_rdata in that cycle.
  - The other master's rdata holds its previous value.
- Back-to-back operation: one access per cycle sustained. A write directly following a read is legal (the RAM handles it).
- busy = any tag-valid | state!=IDLE.

Test Plan:
- Single master: reset, then m0 writes 0xDEADBEEF to adr 0x10 -> m0_gnt same cycle; next cycle ram_wr_en=1, ram_adr=0x10, ram_wdata=0xDEADBEEF.
- Read return: m1 reads adr 0x10 (RD_LAT=1) -> m1_rvalid=1 with m1_rdata=0xDEADBEEF exactly 2 cycles after grant; m0_rvalid stays 0.
- Round-robin: m0 and m1 both req continuously, no lock, for 4 cycles -> grants alternate 0,1,0,1.
- Lock burst: m1 issues 3 reads with lock=1,1,0 while m0 reqs -> m1 granted 3 consecutive cycles, m0_gnt=0, m0 granted in the 4th cycle.
- Lock abandon: m0 locks, then drops req -> FSM returns to IDLE next cycle and a pending m1 req is granted.
- Reset mid-read: assert reset the cycle after an m1 read grant -> no m1_rvalid afterwards; all outputs 0, busy=0.
